// File: rtl/addsub_pipe.sv
// Pipelined add/subtract unit with valid/ready handshakes, per-beat add/sub and
// signed/unsigned select, optional saturation and carry/overflow/zero/negative flags.
module addsub_pipe #(
    parameter int WIDTH    = 32,
    parameter int STAGES   = 2,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op_sub,
    input  logic             op_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             carry;
        logic             ovf;
        logic             zero;
        logic             neg;
    } beat_t;

    logic [WIDTH-1:0] bb;
    logic [WIDTH:0]   sum;
    logic             cy;
    logic             sovf;
    logic             ovf_c;
    beat_t            calc;

    // All arithmetic happens on the way into stage 0; later stages only carry the beat.
    always_comb begin
        bb    = op_sub ? ~b : b;
        sum   = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, op_sub};
        cy    = op_sub ? ~sum[WIDTH] : sum[WIDTH];
        sovf  = (a[WIDTH-1] == bb[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        ovf_c = op_signed ? sovf : cy;

        calc.res = sum[WIDTH-1:0];
        if ((SATURATE != 0) && ovf_c) begin
            if (op_signed)
                calc.res = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
            else
                calc.res = op_sub ? '0 : '1;
        end
        calc.carry = cy;
        calc.ovf   = ovf_c;
        calc.zero  = (calc.res == '0);
        calc.neg   = calc.res[WIDTH-1];
    end

    logic [STAGES-1:0] valid_q;
    beat_t             data_q [STAGES];
    logic [STAGES-1:0] load;

    // Stage k can load when it or any later stage has a hole, or the consumer drains.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            load[k] = out_ready;
            for (int j = k; j < STAGES; j++) begin
                if (!valid_q[j])
                    load[k] = 1'b1;
            end
        end
    end

    assign in_ready = load[0] && !reset;

    // NOTE: state is updated with non-blocking assignments so every stage samples
    // the pre-edge value of its predecessor regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            // NOTE: the data registers are reset as well because result and flags
            // are required to read zero after reset, not just out_valid.
            for (int k = 0; k < STAGES; k++)
                data_q[k] <= '0;
        end else begin
            if (load[0]) begin
                valid_q[0] <= in_valid;
                if (in_valid)
                    data_q[0] <= calc;
            end
            for (int k = 1; k < STAGES; k++) begin
                if (load[k]) begin
                    valid_q[k] <= valid_q[k-1];
                    if (valid_q[k-1])
                        data_q[k] <= data_q[k-1];
                end
            end
        end
    end

    assign out_valid = valid_q[STAGES-1];
    assign result    = data_q[STAGES-1].res;
    assign carry     = data_q[STAGES-1].carry;
    assign overflow  = data_q[STAGES-1].ovf;
    assign zero      = data_q[STAGES-1].zero;
    assign negative  = data_q[STAGES-1].neg;

endmodule
